// File: rtl/fancy_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fancy_pkg
// Description : Shared encodings for the PWM duty scheduler. This package
//               holds the scan FSM states and the offsets of the control
//               word and duty words in the parameter table.
// Revision    : 1.0  initial release
// ============================================================================
package fancy_pkg;

  // Scan FSM states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_READY = 2'd3
  } sched_state_t;

  // Layout of one table, relative to BASE_ADDR.
  // Scan index 0 is the control word. Scan index 1..NUM_CH are the duty words.
  localparam int CTRL_OFS = 0;
  localparam int DUTY_OFS = 1;

  // Width of the RAM read port
  localparam int RDATA_W = 32;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_duty_bank.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_bank
// Description : Holds a shadow copy and an active copy of the per-channel
//               enables and duties. A scan fills the shadow copy one word at
//               a time. A commit copies the whole shadow copy to the active
//               copy in one cycle, and duties of disabled channels are forced
//               to zero as they are copied.
// Revision    : 1.0  initial release
// ============================================================================
module pwm_duty_bank
  import fancy_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DUTY_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     capture,
  input  logic [IDX_W-1:0]         capture_idx,
  input  logic [RDATA_W-1:0]       capture_data,
  input  logic                     commit,
  output logic [NUM_CH*DUTY_W-1:0] duty_flat,
  output logic [NUM_CH-1:0]        ch_enable
);

  // Highest data bit that any table word actually uses
  localparam int USED_W = max_int(NUM_CH, DUTY_W);

  logic [NUM_CH-1:0]             shadow_en;
  logic [NUM_CH-1:0][DUTY_W-1:0] shadow_duty;
  logic [NUM_CH-1:0][DUTY_W-1:0] active_duty;

  // The upper RAM bits carry no table information. They are ignored on purpose.
  generate
    if (USED_W < RDATA_W) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^capture_data[RDATA_W-1:USED_W];
    end
  endgenerate

  // Fill the shadow copy one table word at a time as the scan delivers it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_en   <= '0;
      shadow_duty <= '0;
    end else if (capture) begin
      if (capture_idx == IDX_W'(CTRL_OFS)) begin
        shadow_en <= capture_data[NUM_CH-1:0];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (capture_idx == IDX_W'(DUTY_OFS + i)) begin
          shadow_duty[i] <= capture_data[DUTY_W-1:0];
        end
      end
    end
  end

  // Copy the full shadow set to the active outputs at once, with disabled channels masked to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_enable   <= '0;
      active_duty <= '0;
    end else if (commit) begin
      ch_enable <= shadow_en;
      for (int i = 0; i < NUM_CH; i++) begin
        active_duty[i] <= shadow_en[i] ? shadow_duty[i] : '0;
      end
    end
  end

  assign duty_flat = active_duty;

endmodule
`default_nettype wire

// File: rtl/pwm_duty_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_scheduler
// Description : Scans the PWM parameter table through a read-only RAM port.
//               The table holds one control word and NUM_CH duty words. The
//               scan loads the words into shadow registers. The shadow data
//               is committed to the PWM outputs only on a period boundary, so
//               a PWM period never sees a half-updated table.
// Revision    : 1.0  initial release
// ============================================================================
module pwm_duty_scheduler
  import fancy_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int DUTY_W     = 16,
  parameter int ADDR_W     = 6,
  parameter int BASE_ADDR  = 0,
  parameter int RD_LATENCY = 1
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  input  logic                     tick,
  input  logic                     period_start,
  output logic [ADDR_W-1:0]        ram_address,
  input  logic [RDATA_W-1:0]       ram_rdata,
  output logic [NUM_CH*DUTY_W-1:0] duty_flat,
  output logic [NUM_CH-1:0]        ch_enable,
  output logic                     update_pulse,
  output logic                     busy,
  output logic                     overrun
);

  localparam int                IDX_W    = $clog2(NUM_CH + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DUTY_OFS + NUM_CH - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [1:0]        LAT      = 2'(RD_LATENCY);

  // Reject parameter sets that the table layout or the wait counter cannot support
  generate
    if (NUM_CH < 1 || NUM_CH > 31) begin : g_bad_num_ch
      $error("pwm_duty_scheduler: NUM_CH must be in 1..31");
    end
    if (BASE_ADDR + NUM_CH > (2 ** ADDR_W) - 1) begin : g_bad_addr
      $error("pwm_duty_scheduler: parameter table does not fit in the RAM address space");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
      $error("pwm_duty_scheduler: RD_LATENCY must be 1 or 2");
    end
  endgenerate

  sched_state_t     state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [1:0]       wait_cnt;
  logic             capture;
  logic             commit;

  assign idx_next = idx + IDX_W'(1);

  // Read data is valid on the last WAIT tick.
  // The RAM address has been stable since this word entered ISSUE.
  assign capture = tick && (state == S_WAIT) && (wait_cnt == 2'd1);
  assign commit  = tick && (state == S_READY) && period_start;

  // Scan sequencer.
  // The address is loaded when the FSM enters ISSUE, so the ISSUE tick already counts toward the read latency.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      wait_cnt     <= '0;
      ram_address  <= BASE;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      update_pulse <= 1'b0;
    end else begin
      update_pulse <= 1'b0;
      if (tick) begin
        case (state)
          S_IDLE: begin
            if (period_start) begin
              state       <= S_ISSUE;
              idx         <= '0;
              ram_address <= BASE;
              busy        <= 1'b1;
            end
          end
          S_ISSUE: begin
            if (period_start) begin
              overrun <= 1'b1;
            end
            wait_cnt <= LAT;
            state    <= S_WAIT;
          end
          S_WAIT: begin
            if (period_start) begin
              overrun <= 1'b1;
            end
            if (wait_cnt == 2'd1) begin
              if (idx == LAST_IDX) begin
                state <= S_READY;
                busy  <= 1'b0;
              end else begin
                idx         <= idx_next;
                ram_address <= BASE + ADDR_W'(idx_next);
                state       <= S_ISSUE;
              end
            end else begin
              wait_cnt <= wait_cnt - 2'd1;
            end
          end
          S_READY: begin
            if (period_start) begin
              update_pulse <= 1'b1;
              state        <= S_ISSUE;
              idx          <= '0;
              ram_address  <= BASE;
              busy         <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  pwm_duty_bank #(
    .NUM_CH (NUM_CH),
    .DUTY_W (DUTY_W),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk          (CLOCK_50),
    .rst_n        (reset_n),
    .capture      (capture),
    .capture_idx  (idx),
    .capture_data (ram_rdata),
    .commit       (commit),
    .duty_flat    (duty_flat),
    .ch_enable    (ch_enable)
  );

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_duty_scheduler
// Description : Bench for pwm_duty_scheduler. It has two instances:
//               - Instance 0 uses latency 1 and base 0.
//               - Instance 1 uses latency 2 and base 3.
//               Each instance reads a RAM model with a tick-registered read.
//               A reference model, updated once per tick, follows the table
//               rules. It predicts enables, duties, busy, overrun and commit
//               pulses.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pwm_duty_scheduler;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              tick = 1'b0;
  logic [1:0]        ps = 2'b00;
  logic [1:0][5:0]   addr;
  logic [1:0][31:0]  rdata;
  logic [1:0][127:0] flat;
  logic [1:0][7:0]   en;
  logic [1:0]        upd;
  logic [1:0]        busy;
  logic [1:0]        ovr;

  int n_tests = 0;
  int n_fail  = 0;
  bit noise_en = 1'b0;

  // RAM contents and the tick-registered read pipelines
  logic [31:0] mem [2][64];
  logic [31:0] q0 = '0, q1a = '0, q1b = '0;

  // Reference model state
  logic [7:0]  m_snap_en   [2];
  logic [15:0] m_snap_duty [2][8];
  logic [15:0] m_act       [2][8];
  logic [7:0]  m_en        [2];
  bit          m_scan [2], m_ready [2], m_ovr [2], m_commit [2];
  int          m_left [2];
  int          m_ncommit [2] = '{0, 0};
  int          pulse_cyc [2] = '{0, 0};

  typedef struct packed {
    logic [7:0]   ctrl;
    logic [15:0]  ofs;
    logic [127:0] exp_flat;
    logic [7:0]   exp_en;
  } vec_t;
  vec_t vecs [3];

  pwm_duty_scheduler #(.NUM_CH(8), .DUTY_W(16), .ADDR_W(6), .BASE_ADDR(0), .RD_LATENCY(1)) dut0 (
    .CLOCK_50(clk), .reset_n(reset_n), .tick(tick), .period_start(ps[0]),
    .ram_address(addr[0]), .ram_rdata(rdata[0]), .duty_flat(flat[0]), .ch_enable(en[0]),
    .update_pulse(upd[0]), .busy(busy[0]), .overrun(ovr[0]));

  pwm_duty_scheduler #(.NUM_CH(8), .DUTY_W(16), .ADDR_W(6), .BASE_ADDR(3), .RD_LATENCY(2)) dut1 (
    .CLOCK_50(clk), .reset_n(reset_n), .tick(tick), .period_start(ps[1]),
    .ram_address(addr[1]), .ram_rdata(rdata[1]), .duty_flat(flat[1]), .ch_enable(en[1]),
    .update_pulse(upd[1]), .busy(busy[1]), .overrun(ovr[1]));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tick) begin
      q0  <= mem[0][addr[0]];
      q1a <= mem[1][addr[1]];
      q1b <= q1a;
    end
  end
  assign rdata[0] = q0;
  assign rdata[1] = q1b;

  always @(posedge clk) begin
    if (upd[0]) pulse_cyc[0] <= pulse_cyc[0] + 1;
    if (upd[1]) pulse_cyc[1] <= pulse_cyc[1] + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  function automatic int base_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_scan[d] = 0; m_ready[d] = 0; m_ovr[d] = 0; m_commit[d] = 0; m_left[d] = 0;
      m_en[d] = '0; m_snap_en[d] = '0;
      for (int i = 0; i < 8; i++) begin
        m_act[d][i] = '0;
        m_snap_duty[d][i] = '0;
      end
    end
  endtask

  // One tick of the table rules.
  // The model takes a snapshot of the table when a scan starts. After
  // (NUM_CH+1)*(lat+1) ticks the snapshot is ready, and the next
  // period_start commits it.
  task automatic model_step(input int d, input bit p);
    m_commit[d] = 1'b0;
    if (m_scan[d]) begin
      if (p) m_ovr[d] = 1'b1;
      m_left[d]--;
      if (m_left[d] == 0) begin
        m_scan[d] = 1'b0;
        m_ready[d] = 1'b1;
      end
    end else if (p) begin
      if (m_ready[d]) begin
        m_en[d] = m_snap_en[d];
        for (int i = 0; i < 8; i++) m_act[d][i] = m_snap_en[d][i] ? m_snap_duty[d][i] : 16'h0;
        m_commit[d] = 1'b1;
        m_ncommit[d]++;
      end
      m_snap_en[d] = mem[d][base_of(d)][7:0];
      for (int i = 0; i < 8; i++) m_snap_duty[d][i] = mem[d][base_of(d) + 1 + i][15:0];
      m_scan[d] = 1'b1;
      m_ready[d] = 1'b0;
      m_left[d] = 9 * (lat_of(d) + 1);
    end
  endtask

  task automatic check_dut(input int d);
    logic [127:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) e[16*i +: 16] = m_act[d][i];
    chk($sformatf("d%0d_duty_flat", d), flat[d], e);
    chk($sformatf("d%0d_ch_enable", d), en[d], m_en[d]);
    chk($sformatf("d%0d_busy", d), busy[d], m_scan[d]);
    chk($sformatf("d%0d_overrun", d), ovr[d], m_ovr[d]);
    chk($sformatf("d%0d_update_pulse", d), upd[d], m_commit[d]);
  endtask

  // One tick cycle followed by 15 idle cycles. When noise is on, period_start toggles while tick is low.
  task automatic do_tick(input bit p0, input bit p1);
    @(negedge clk);
    tick = 1'b1;
    ps = {p1, p0};
    @(posedge clk);
    model_step(0, p0);
    model_step(1, p1);
    #1;
    tick = 1'b0;
    ps = 2'b00;
    check_dut(0);
    check_dut(1);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      ps = noise_en ? 2'($urandom) : 2'b00;
    end
    @(negedge clk);
    ps = 2'b00;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_dut(0);
    check_dut(1);
    chk("d0_addr_reset", addr[0], 6'd0);
    chk("d1_addr_reset", addr[1], 6'd3);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (busy[d] && n < 60) begin
      do_tick(1'b0, 1'b0);
      n++;
    end
    chk($sformatf("d%0d_idle_bound", d), busy[d], 1'b0);
  endtask

  task automatic measure_scan(input int d, input int exp_len);
    int n = 0;
    while (busy[d] && n < 60) begin
      do_tick(1'b0, 1'b0);
      n++;
    end
    chk($sformatf("d%0d_scan_len", d), n, exp_len);
  endtask

  task automatic load_table(input int d, input logic [7:0] ctrl, input logic [15:0] ofs);
    mem[d][base_of(d)] = {16'hDEAD, 8'h5A, ctrl};
    for (int i = 0; i < 8; i++) mem[d][base_of(d) + 1 + i] = {16'hDEAD, 16'(i * 1000) + ofs};
  endtask

  task automatic rand_table(input int d);
    for (int k = 0; k < 9; k++) mem[d][base_of(d) + k] = $urandom;
  endtask

  initial begin
    vecs[0] = '{8'hFF, 16'h0000,
                {16'h1B58, 16'h1770, 16'h1388, 16'h0FA0, 16'h0BB8, 16'h07D0, 16'h03E8, 16'h0000}, 8'hFF};
    vecs[1] = '{8'h05, 16'h0005,
                {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h07D5, 16'h0000, 16'h0005}, 8'h05};
    vecs[2] = '{8'h82, 16'h0100,
                {16'h1C58, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h04E8, 16'h0000}, 8'h82};
    for (int d = 0; d < 2; d++) for (int a = 0; a < 64; a++) mem[d][a] = '0;
    model_reset();

    // Reset state
    apply_reset();

    // Table-driven commits on instance 0: enables, masking, 18-tick scan
    for (int v = 0; v < 3; v++) begin
      wait_idle(0);
      load_table(0, vecs[v].ctrl, vecs[v].ofs);
      do_tick(1'b1, 1'b0);
      measure_scan(0, 18);
      do_tick(1'b1, 1'b0);
      chk($sformatf("vec%0d_duty_flat", v), flat[0], vecs[v].exp_flat);
      chk($sformatf("vec%0d_ch_enable", v), en[0], vecs[v].exp_en);
    end

    // period_start mid-scan: overrun is sticky, and no early commit happens
    wait_idle(0);
    load_table(0, vecs[0].ctrl, vecs[0].ofs);
    do_tick(1'b1, 1'b0);
    repeat (4) do_tick(1'b0, 1'b0);
    do_tick(1'b1, 1'b0);
    chk("ovr_set", ovr[0], 1'b1);
    chk("ovr_no_early_commit", flat[0], vecs[2].exp_flat);
    wait_idle(0);
    chk("ovr_hold_after_scan", flat[0], vecs[2].exp_flat);
    chk("ovr_sticky", ovr[0], 1'b1);
    do_tick(1'b1, 1'b0);
    chk("ovr_commit_next", flat[0], vecs[0].exp_flat);

    // Rewrite duty[4] after its word has been read: the old value commits first
    wait_idle(0);
    do_tick(1'b1, 1'b0);
    repeat (14) do_tick(1'b0, 1'b0);
    mem[0][5] = 32'hDEAD_FFFF;
    wait_idle(0);
    do_tick(1'b1, 1'b0);
    chk("rewrite_old_ch4", flat[0][79:64], 16'h0FA0);
    wait_idle(0);
    do_tick(1'b1, 1'b0);
    chk("rewrite_new_ch4", flat[0][79:64], 16'hFFFF);

    // Reset mid-scan: the partial scan must never be committed
    repeat (3) do_tick(1'b0, 1'b0);
    apply_reset();
    do_tick(1'b1, 1'b0);
    wait_idle(0);
    chk("post_reset_no_commit", flat[0], 128'h0);
    do_tick(1'b1, 1'b0);
    chk("post_reset_commit_ch4", flat[0][79:64], 16'hFFFF);

    // Latency 2 at base 3: 27-tick scan, and the upper 0xDEAD bits stay out of duty_flat
    load_table(1, vecs[0].ctrl, vecs[0].ofs);
    do_tick(1'b0, 1'b1);
    measure_scan(1, 27);
    do_tick(1'b0, 1'b1);
    chk("lat2_duty_flat", flat[1], vecs[0].exp_flat);
    chk("lat2_ch_enable", en[1], vecs[0].exp_en);

    // Random tables, random period_starts, and period_start noise while tick is low
    noise_en = 1'b1;
    for (int t = 0; t < 400; t++) begin
      for (int d = 0; d < 2; d++) begin
        if (!m_scan[d] && $urandom_range(0, 3) == 0) rand_table(d);
      end
      if (t == 200) apply_reset();
      do_tick($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
    end
    noise_en = 1'b0;
    repeat (2) do_tick(1'b0, 1'b0);

    chk("d0_pulse_cycles", pulse_cyc[0], m_ncommit[0]);
    chk("d1_pulse_cycles", pulse_cyc[1], m_ncommit[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
